regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the ARM pipeline. It replaces the single-write, two-read register file with:

- configurable width, depth and read-port count;
- two prioritised write-back ports;
- write-through bypass;
- a per-register pending-write scoreboard;
- a sequenced initialisation that loads every entry after reset.

It sits between ID (reads, locks) and WB (writes), so the hazard unit can use the busy flags directly.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth is 2**ADDR_W
- NUM_RD, 3, number of read ports
- INIT_MODE, 1, init value per entry: 0 = zero, 1 = entry index (zero-extended)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i's register has an outstanding, not-yet-arriving write
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_W / DATA_W  write port 0
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  write port 1 (higher priority)
- lock_en / lock_addr  in  1 / ADDR_W  mark a register as pending write (instruction issued)
- ready  out  1  initialisation complete; block accepts writes and locks

## Operation
- FSM has two states, INIT and RUN; 2**ADDR_W-entry array; ADDR_W-bit init counter; 2**ADDR_W pending bits.
- rst=1 at a rising edge:
  - state <= INIT, counter <= 0, all pending bits <= 0;
  - array contents are not cleared by reset itself.
- INIT:
  - each rising edge with rst=0 writes the array entry at the counter with the INIT_MODE value, then increments the counter;
  - at the edge where the counter is 2**ADDR_W-1, state <= RUN.
  - wr*_en and lock_en are ignored.
  - Outputs: ready=0, rd_data=0, rd_busy=0.
- RUN, write: if wr0_en, data[wr0_addr] <= wr0_data; if wr1_en, data[wr1_addr] <= wr1_data. Same address on both ports: port 1 wins.
- RUN, bypass: rd_data[i] selects in priority order:
  - wr1_data if wr1_en and wr1_addr == rd_addr[i];
  - else wr0_data if wr0_en and wr0_addr == rd_addr[i];
  - else data[rd_addr[i]].
- RUN, scoreboard:
  - any enabled write to address a clears pending[a];
  - lock_en sets pending[lock_addr];
  - lock and write to the same address in one cycle: set wins (the newer instruction owns the register).
- rd_busy[i] = pending[rd_addr[i]] AND NOT (a write to rd_addr[i] is enabled this cycle). Forwarded data counts as available.
- Read ports are fully independent; any number may share an address.

## Timing
- Reset values: ready=0, rd_busy=0, rd_data=0, all pending=0.
- Init latency: ready rises exactly 2**ADDR_W rising edges after the first edge with rst=0 (16 for the default).
- Write latency: write-to-array takes 1 edge; the value is visible on rd_data combinationally in the same cycle via bypass.
- Lock-to-busy latency: a lock at edge t makes rd_busy high for that address from t+1 onward.
- Mid-operation reset: rst asserted in any state restarts INIT from counter 0 at the next edge. Pending writes are dropped and ready falls in the cycle after that edge.
- rst held high over multiple edges: remains at counter 0; INIT progresses only on rst=0 edges.
- Address wrap: none. Every ADDR_W-bit address is valid, and the init counter stops at the last entry.

## Test plan
- Reset then idle, default params: ready=0 for 16 edges and 1 after. rd_addr={5,15,0} gives rd_data={5,15,0} (INIT_MODE=1). With INIT_MODE=0, all reads return 0.
- Dual write, same address, RUN: wr0 (R3 <= 0xAAAA0000), wr1 (R3 <= 0x5555FFFF). rd_data for R3 is 0x5555FFFF in the same cycle and after the edge.
- Bypass plus array read: wr0 R7 <= 0x12345678 while ports read {R7,R7,R2}. Output {0x12345678,0x12345678,2} combinationally, and R7 persists the next cycle with wr0_en=0.
- Scoreboard: lock R4 at edge t, so rd_busy for R4 is 1 at t+1. Write R4 in cycle t+3: rd_busy=0 during that cycle and rd_data = write data. Lock and write R4 together: pending stays 1.
- Ignored operations: wr0_en and lock_en asserted during INIT have no effect. After ready, R9 reads 9 and rd_busy=0.
- Reset mid-run: lock R1, write R2 <= 0xDEAD, then assert rst one cycle. ready=0 for 16 edges, then R2 reads 2 and rd_busy for R1 is 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write-back ports, write-through
// bypass, a pending-write scoreboard and a sequenced post-reset initialisation.

module regfile_mp_rd #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic                         run,
   input  logic [ADDR_W-1:0]            addr,
   input  logic                         wr0_en,
   input  logic [ADDR_W-1:0]            wr0_addr,
   input  logic [DATA_W-1:0]            wr0_data,
   input  logic                         wr1_en,
   input  logic [ADDR_W-1:0]            wr1_addr,
   input  logic [DATA_W-1:0]            wr1_data,
   input  logic [DEPTH-1:0]             pending,
   input  logic [DEPTH-1:0][DATA_W-1:0] mem,
   output logic [DATA_W-1:0]            data,
   output logic                         busy
);
   logic hit0, hit1;

   assign hit1 = wr1_en && (wr1_addr == addr);
   assign hit0 = wr0_en && (wr0_addr == addr);

   always_comb begin
      data = '0;
      busy = 1'b0;
      if (run) begin
         if (hit1)      data = wr1_data;
         else if (hit0) data = wr0_data;
         else           data = mem[addr];
         // a write landing this cycle is forwarded, so the reader need not stall
         busy = pending[addr] && !(hit0 || hit1);
      end
   end
endmodule

module regfile_mp #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int NUM_RD    = 3,
   parameter int INIT_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     lock_en,
   input  logic [ADDR_W-1:0]        lock_addr,
   output logic                     ready
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {INIT, RUN} state_t;

   state_t                     state, state_nxt;
   logic [ADDR_W-1:0]          cnt, cnt_nxt;
   logic [DEPTH-1:0]           pending, pending_nxt;
   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DATA_W-1:0]          init_val;
   logic                       run;

   assign run      = (state == RUN);
   assign ready    = run;
   assign init_val = (INIT_MODE != 0) ? DATA_W'(cnt) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         cnt     <= '0;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pending <= pending_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      case (state)
         INIT: begin
            if (cnt == '1) state_nxt = RUN;
            else           cnt_nxt   = cnt + 1'b1;
         end
         RUN: begin
            if (wr0_en)  pending_nxt[wr0_addr]  = 1'b0;
            if (wr1_en)  pending_nxt[wr1_addr]  = 1'b0;
            // set after clear: a newly issued instruction owns the register
            if (lock_en) pending_nxt[lock_addr] = 1'b1;
         end
         default: state_nxt = INIT;
      endcase
   end

   // storage is not reset; INIT rewrites every entry instead
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[cnt] <= init_val;
         end else begin
            if (wr0_en) mem[wr0_addr] <= wr0_data;
            if (wr1_en) mem[wr1_addr] <= wr1_data;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_mp_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd (
         .run      (run),
         .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
         .wr0_en   (wr0_en),
         .wr0_addr (wr0_addr),
         .wr0_data (wr0_data),
         .wr1_en   (wr1_en),
         .wr1_addr (wr1_addr),
         .wr1_data (wr1_data),
         .pending  (pending),
         .mem      (mem),
         .data     (rd_data[i*DATA_W +: DATA_W]),
         .busy     (rd_busy[i])
      );
   end
endmodule
